// File: rtl/inst_rr_scheduler_if.sv
// Request-side and output-side handshake bundle for the instruction round-robin scheduler.
// master = queue/PE/downstream side, slave = scheduler.
interface inst_rr_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int PKT_W = 18
);
    localparam int SRC_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*PKT_W-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       pe_ack;
    logic                  out_valid;
    logic [PKT_W-1:0]      out_data;
    logic [SRC_W-1:0]      out_src;
    logic                  out_ready;
    logic                  node_err;

    modport master (
        output req_valid, req_data, pe_ack, out_ready,
        input  req_ready, out_valid, out_data, out_src, node_err
    );

    modport slave (
        input  req_valid, req_data, pe_ack, out_ready,
        output req_ready, out_valid, out_data, out_src, node_err
    );
endinterface

// File: rtl/inst_rr_scheduler.sv
// Round-robin scheduler of per-PE instruction packets into one registered output; ifmap packets gated on PE credits.
// Latency: 1 cycle from accept edge to out_valid; 1 packet/cycle while out_ready stays high.
// Backpressure: out_valid & !out_ready holds the output register and drops all req_ready.
module inst_rr_scheduler #(
    parameter int NREQ      = 4,
    parameter int PKT_W     = 18,
    parameter int NODE_W    = 4,
    parameter int MAX_CRED  = 3,
    parameter int INIT_CRED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_rr_scheduler_if.slave bus
);
    localparam int SRC_W  = $clog2(NREQ);
    localparam int CRED_W = $clog2(MAX_CRED + 1);

    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [CRED_W-1:0] cred_q [NREQ];
    logic [CRED_W-1:0] cred_d [NREQ];
    logic              out_valid_q, out_valid_d;
    logic [PKT_W-1:0]  out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic              node_err_q, node_err_d;

    logic [PKT_W-1:0]  pkt [NREQ];
    logic [NREQ-1:0]   ifmap, elig, grant, cons;
    logic              any_elig, grant_vld, slot_free;
    logic [SRC_W-1:0]  winner;

    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int k);
        return SRC_W'((int'(base) + k) % NREQ);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pkt[i]   = bus.req_data[i*PKT_W +: PKT_W];
            ifmap[i] = (pkt[i][NODE_W+1:NODE_W] == 2'b00);
            elig[i]  = bus.req_valid[i] & (~ifmap[i] | (cred_q[i] != '0));
        end
    end

    // Scan from the far end so the last hit written is the one closest to ptr.
    always_comb begin
        slot_free = ~out_valid_q | bus.out_ready;
        any_elig  = 1'b0;
        winner    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[rr_idx(ptr_q, k)]) begin
                any_elig = 1'b1;
                winner   = rr_idx(ptr_q, k);
            end
        end
        grant_vld = any_elig & slot_free;
        grant     = '0;
        if (grant_vld) grant[winner] = 1'b1;
        cons      = grant & ifmap;
    end

    assign bus.req_ready = grant & {NREQ{rst_n}};

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        node_err_d  = node_err_q;
        if (grant_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = pkt[winner];
            out_src_d   = winner;
            ptr_d       = (winner == SRC_W'(NREQ - 1)) ? '0 : winner + 1'b1;
            if (pkt[winner][NODE_W-1:0] != NODE_W'(winner)) node_err_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        // A same-cycle ack and consume cancel, even at saturation.
        for (int i = 0; i < NREQ; i++) begin
            cred_d[i] = cred_q[i];
            if (bus.pe_ack[i] & ~cons[i] & (cred_q[i] != CRED_W'(MAX_CRED)))
                cred_d[i] = cred_q[i] + 1'b1;
            else if (cons[i] & ~bus.pe_ack[i])
                cred_d[i] = cred_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            node_err_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) cred_q[i] <= CRED_W'(INIT_CRED);
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            node_err_q  <= node_err_d;
            for (int i = 0; i < NREQ; i++) cred_q[i] <= cred_d[i];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.node_err  = node_err_q;
endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Bench for inst_rr_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
module tb_inst_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int PKT_W = 18;
    localparam int MAXC  = 3;
    localparam int INITC = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    inst_rr_scheduler_if #(.NREQ(NREQ), .PKT_W(PKT_W)) bus();

    inst_rr_scheduler #(
        .NREQ(NREQ), .PKT_W(PKT_W), .NODE_W(4), .MAX_CRED(MAXC), .INIT_CRED(INITC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: credits per PE, next queue to favour, and the output register contents.
    int               m_cred [NREQ];
    int               m_ptr;
    logic             m_ov, m_err;
    logic [PKT_W-1:0] m_od;
    int               m_os;

    function automatic logic [PKT_W-1:0] mk(input logic [11:0] tag, input logic [1:0] kind, input logic [3:0] node);
        return {tag, kind, node};
    endfunction

    function automatic logic [PKT_W-1:0] slot(input int i);
        return bus.req_data[i*PKT_W +: PKT_W];
    endfunction

    function automatic int model_pick();
        logic [PKT_W-1:0] p;
        int i;
        if (!rst_n) return -1;
        if (m_ov && !bus.out_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            p = slot(i);
            if (bus.req_valid[i] && (p[5:4] != 2'b00 || m_cred[i] > 0)) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        int w;
        r = '0;
        w = model_pick();
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_cred[i] = INITC;
        m_ptr = 0; m_ov = 1'b0; m_err = 1'b0; m_od = '0; m_os = 0;
    endtask

    task automatic set_slot(input int i, input logic [PKT_W-1:0] p);
        bus.req_data[i*PKT_W +: PKT_W] = p;
    endtask

    // One clock: decide from pre-edge inputs, advance the model at the edge, settle 1 time unit.
    task automatic tick();
        int w;
        logic [PKT_W-1:0] p;
        logic [NREQ-1:0] ack;
        logic ordy;
        w = model_pick(); ack = bus.pe_ack; ordy = bus.out_ready; p = '0;
        if (w >= 0) p = slot(w);
        @(posedge clk);
        for (int i = 0; i < NREQ; i++) begin
            m_cred[i] = m_cred[i] + int'(ack[i]) - ((w == i && p[5:4] == 2'b00) ? 1 : 0);
            if (m_cred[i] > MAXC) m_cred[i] = MAXC;
        end
        if (w >= 0) begin
            m_od = p; m_os = w; m_ov = 1'b1; m_ptr = (w + 1) % NREQ;
            if (p[3:0] != 4'(w)) m_err = 1'b1;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic hard_reset();
        bus.req_valid = '0; bus.pe_ack = '0; bus.out_ready = 1'b0; bus.req_data = '0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = 4'hF; bus.pe_ack = '0; bus.out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_slot(i, mk(12'(i), 2'b01, 4'(i)));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        tests_run++; if (bus.out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        tests_run++; if (bus.out_src !== '0) begin tests_failed++; $display("FAIL reset_out_src got %0d exp 0", bus.out_src); end
        tests_run++; if (bus.node_err !== 1'b0) begin tests_failed++; $display("FAIL reset_node_err got %b exp 0", bus.node_err); end
        @(posedge clk);
        #1;
        tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_hold_valid got %b exp 0", bus.out_valid); end
        #2;
        rst_n = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_order();
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [PKT_W-1:0] pk [NREQ];
        logic [NREQ-1:0] e;
        hard_reset();
        for (int i = 0; i < NREQ; i++) begin
            pk[i] = mk(12'h100 + 12'(i), 2'b01, 4'(i));
            set_slot(i, pk[i]);
        end
        bus.req_valid = 4'hF; bus.out_ready = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            e = 4'b0001 << seq[c];
            tests_run++; if (bus.req_ready !== e) begin tests_failed++; $display("FAIL rr_ready c%0d got %b exp %b", c, bus.req_ready, e); end
            tick();
            tests_run++; if (bus.out_src !== 2'(seq[c])) begin tests_failed++; $display("FAIL rr_src c%0d got %0d exp %0d", c, bus.out_src, seq[c]); end
            tests_run++; if (bus.out_data !== pk[seq[c]] || bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rr_data c%0d got %h/%b exp %h/1", c, bus.out_data, bus.out_valid, pk[seq[c]]); end
        end
        tests_run++; if (bus.node_err !== 1'b0) begin tests_failed++; $display("FAIL rr_node_err got %b exp 0", bus.node_err); end
        bus.req_valid = '0;
    endtask

    task automatic test_credit_stall();
        logic [PKT_W-1:0] a, b;
        hard_reset();
        a = mk(12'h0A1, 2'b00, 4'd2);
        b = mk(12'h0B2, 2'b00, 4'd2);
        set_slot(2, a); bus.req_valid = 4'b0100; bus.out_ready = 1'b1;
        #1;
        tests_run++; if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL cred_first_ready got %b exp 0100", bus.req_ready); end
        tick();
        tests_run++; if (bus.out_data !== a) begin tests_failed++; $display("FAIL cred_first_data got %h exp %h", bus.out_data, a); end
        set_slot(2, b);
        #1;
        for (int c = 0; c < 3; c++) begin
            tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL cred_stall c%0d got %b exp 0000", c, bus.req_ready); end
            tick();
        end
        tests_run++; if (bus.out_valid !== 1'b0 || bus.out_data !== a) begin tests_failed++; $display("FAIL cred_drain got %b/%h exp 0/%h", bus.out_valid, bus.out_data, a); end
        bus.pe_ack = 4'b0100;
        #1;
        tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL cred_ack_cycle got %b exp 0000", bus.req_ready); end
        tick();
        bus.pe_ack = '0;
        #1;
        tests_run++; if (bus.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL cred_after_ack got %b exp 0100", bus.req_ready); end
        tick();
        tests_run++; if (bus.out_data !== b || bus.out_src !== 2'd2) begin tests_failed++; $display("FAIL cred_second got %h/%0d exp %h/2", bus.out_data, bus.out_src, b); end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [PKT_W-1:0] pk [NREQ];
        hard_reset();
        for (int i = 0; i < NREQ; i++) begin
            pk[i] = mk(12'h200 + 12'(i), 2'b10, 4'(i));
            set_slot(i, pk[i]);
        end
        bus.req_valid = 4'hF; bus.out_ready = 1'b1;
        #1;
        tick();
        bus.out_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            tests_run++; if (bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready c%0d got %b exp 0000", c, bus.req_ready); end
            tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== pk[0] || bus.out_src !== 2'd0) begin tests_failed++; $display("FAIL bp_hold c%0d got %b/%h/%0d exp 1/%h/0", c, bus.out_valid, bus.out_data, bus.out_src, pk[0]); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        tests_run++; if (bus.req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_release got %b exp 0010", bus.req_ready); end
        tick();
        tests_run++; if (bus.out_src !== 2'd1 || bus.out_data !== pk[1]) begin tests_failed++; $display("FAIL bp_next got %0d/%h exp 1/%h", bus.out_src, bus.out_data, pk[1]); end
        bus.req_valid = '0;
    endtask

    task automatic test_node_err();
        logic [PKT_W-1:0] p;
        hard_reset();
        p = mk(12'h123, 2'b01, 4'd3);
        set_slot(1, p); bus.req_valid = 4'b0010; bus.out_ready = 1'b1;
        #1;
        tick();
        bus.req_valid = '0;
        tests_run++; if (bus.out_data !== p || bus.out_src !== 2'd1) begin tests_failed++; $display("FAIL nerr_fwd got %h/%0d exp %h/1", bus.out_data, bus.out_src, p); end
        tests_run++; if (bus.node_err !== 1'b1) begin tests_failed++; $display("FAIL nerr_set got %b exp 1", bus.node_err); end
        for (int i = 0; i < NREQ; i++) set_slot(i, mk(12'h300, 2'b11, 4'(i)));
        bus.req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            tests_run++; if (bus.node_err !== 1'b1) begin tests_failed++; $display("FAIL nerr_sticky c%0d got %b exp 1", c, bus.node_err); end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_cred_sat();
        int accepted;
        hard_reset();
        bus.pe_ack = 4'b0001;
        for (int c = 0; c < 5; c++) tick();
        bus.pe_ack = '0;
        bus.req_valid = 4'b0001; bus.out_ready = 1'b1;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            set_slot(0, mk(12'(c), 2'b00, 4'd0));
            #1;
            tests_run++; if (bus.req_ready !== exp_ready()) begin tests_failed++; $display("FAIL sat_ready c%0d got %b exp %b", c, bus.req_ready, exp_ready()); end
            if (bus.req_ready[0]) accepted++;
            tick();
        end
        tests_run++; if (accepted !== 3) begin tests_failed++; $display("FAIL sat_count got %0d exp 3", accepted); end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] e;
        hard_reset();
        for (int i = 0; i < NREQ; i++) set_slot(i, mk(12'h400, 2'b01, 4'(i)));
        bus.req_valid = 4'hF; bus.out_ready = 1'b1;
        #1;
        tick(); tick();
        bus.out_ready = 1'b0;
        #1;
        tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre got %b exp 1", bus.out_valid); end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL mid_async got %b/%b exp 0/0000", bus.out_valid, bus.req_ready); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_slot(i, mk(12'h500, 2'b00, 4'(i)));
        bus.out_ready = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            e = (c < 4) ? (4'b0001 << c) : 4'b0000;
            tests_run++; if (bus.req_ready !== e) begin tests_failed++; $display("FAIL mid_after c%0d got %b exp %b", c, bus.req_ready, e); end
            tick();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        logic [3:0] node;
        hard_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                node = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'(i);
                set_slot(i, mk(12'($urandom), 2'($urandom_range(0, 3)), node));
            end
            bus.pe_ack    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            tests_run++; if (bus.req_ready !== exp_ready()) begin tests_failed++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.req_ready, exp_ready()); end
            tick();
            tests_run++; if (bus.out_valid !== m_ov || bus.out_data !== m_od || bus.out_src !== 2'(m_os)) begin tests_failed++; $display("FAIL rnd_out c%0d got %b/%h/%0d exp %b/%h/%0d", c, bus.out_valid, bus.out_data, bus.out_src, m_ov, m_od, m_os); end
            tests_run++; if (bus.node_err !== m_err) begin tests_failed++; $display("FAIL rnd_node_err c%0d got %b exp %b", c, bus.node_err, m_err); end
        end
        bus.req_valid = '0; bus.pe_ack = '0;
    endtask

    initial begin
        bus.req_valid = '0; bus.req_data = '0; bus.pe_ack = '0; bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_rr_order();
        test_credit_stall();
        test_backpressure();
        test_node_err();
        test_cred_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
